// File: rtl/retire_ctrl_pkg.sv
// rtl/retire_ctrl_pkg.sv - shared types and constants for the in-order retire controller
//
// Purpose : physical tag sizing, the zero-register encoding, the ROB head entry
//           record, the controller state encoding and the arch map retire bundle.
// Ports   : none (package).
package retire_ctrl_pkg;

    localparam int PHYS_REG_SIZE = 64;
    localparam int PHYS_REG_BITS = $clog2(PHYS_REG_SIZE);
    localparam int ARCH_IDX_BITS = 5;

    // Arch register 0 is hardwired; a destination of 0 means "no destination".
    localparam logic [ARCH_IDX_BITS-1:0] ZERO_REG = '0;

    typedef struct packed {
        logic                     valid;
        logic                     complete;
        logic [ARCH_IDX_BITS-1:0] arch_idx;
        logic [PHYS_REG_BITS-1:0] phys_tag;
        logic [PHYS_REG_BITS-1:0] old_tag;
        logic                     mispred;
        logic                     uncondbr;
        logic                     halt;
    } rob_head_entry_t;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        RECOVER = 2'd1,
        HALTED  = 2'd2
    } retire_state_e;

    typedef struct packed {
        logic                     retire1;
        logic                     retire2;
        logic                     retire3;
        logic [ARCH_IDX_BITS-1:0] arch_index1;
        logic [ARCH_IDX_BITS-1:0] arch_index2;
        logic [ARCH_IDX_BITS-1:0] arch_index3;
        logic [PHYS_REG_BITS-1:0] arch_tag1;
        logic [PHYS_REG_BITS-1:0] arch_tag2;
        logic [PHYS_REG_BITS-1:0] arch_tag3;
        logic                     uncondbr1;
        logic                     uncondbr2;
        logic                     uncondbr3;
    } arch_map_retire_t;

endpackage

// File: rtl/retire_ctrl_if.sv
// rtl/retire_ctrl_if.sv - ROB head / arch map / free list bundle for the retire controller
//
// Purpose : groups the three ROB head slots (slot 0 oldest) and every commit-side
//           output of retire_ctrl.
// Ports   : head_* (ROB head slots), retire_out / mispredict_out (arch map),
//           rob_retire_cnt (ROB pop count), free_valid / free_tag (free list),
//           squash, restore_map, frontend_stall, halted (pipeline control).
// Modports: slave  - the retire controller (consumes head, drives commit outputs)
//           master - the ROB / pipeline side
interface retire_ctrl_if;
    import retire_ctrl_pkg::*;

    logic [2:0]                          head_valid;
    logic [2:0]                          head_complete;
    logic [2:0][ARCH_IDX_BITS-1:0]       head_arch_idx;
    logic [2:0][PHYS_REG_BITS-1:0]       head_phys_tag;
    logic [2:0][PHYS_REG_BITS-1:0]       head_old_tag;
    logic [2:0]                          head_mispred;
    logic [2:0]                          head_uncondbr;
    logic [2:0]                          head_halt;

    arch_map_retire_t                    retire_out;
    logic [2:0]                          mispredict_out;
    logic [1:0]                          rob_retire_cnt;
    logic [2:0]                          free_valid;
    logic [2:0][PHYS_REG_BITS-1:0]       free_tag;
    logic                                squash;
    logic                                restore_map;
    logic                                frontend_stall;
    logic                                halted;

    modport slave (
        input  head_valid, head_complete, head_arch_idx, head_phys_tag,
               head_old_tag, head_mispred, head_uncondbr, head_halt,
        output retire_out, mispredict_out, rob_retire_cnt, free_valid,
               free_tag, squash, restore_map, frontend_stall, halted
    );

    modport master (
        output head_valid, head_complete, head_arch_idx, head_phys_tag,
               head_old_tag, head_mispred, head_uncondbr, head_halt,
        input  retire_out, mispredict_out, rob_retire_cnt, free_valid,
               free_tag, squash, restore_map, frontend_stall, halted
    );

endinterface

// File: rtl/retire_ctrl_select.sv
// rtl/retire_ctrl_select.sv - in-order retire selection prefix chain for three head slots
//
// Purpose : decides which of the three oldest ROB entries retire this cycle.
// Ports   : enable   in  retirement allowed this cycle
//           valid    in  [2:0] slot holds an instruction
//           complete in  [2:0] slot finished execution
//           mispred  in  [2:0] slot is a resolved mispredicted control instr
//           halt     in  [2:0] slot is a halt
//           ret      out [2:0] slot retires this cycle
//           stop     out [2:0] slot ends the retire group (mispredict or halt)
//           cnt      out [1:0] number of retiring slots
module retire_ctrl_select (
    input  logic       enable,
    input  logic [2:0] valid,
    input  logic [2:0] complete,
    input  logic [2:0] mispred,
    input  logic [2:0] halt,
    output logic [2:0] ret,
    output logic [2:0] stop,
    output logic [1:0] cnt
);

    always_comb begin
        stop = mispred | halt;
        // A stopping slot retires itself but blocks every younger slot.
        ret[0] = enable & valid[0] & complete[0];
        ret[1] = ret[0] & valid[1] & complete[1] & ~stop[0];
        ret[2] = ret[1] & valid[2] & complete[2] & ~stop[1];
        // ret is a prefix mask, so the highest set bit gives the count.
        if (ret[2])      cnt = 2'd3;
        else if (ret[1]) cnt = 2'd2;
        else if (ret[0]) cnt = 2'd1;
        else             cnt = 2'd0;
    end

endmodule

// File: rtl/retire_ctrl.sv
// rtl/retire_ctrl.sv - in-order commit controller between ROB head and arch map table
//
// Purpose : retires 0..3 oldest completed ROB entries per cycle, drives the arch map
//           retire/mispredict inputs, returns old physical tags to the free list and
//           sequences squash / map restore / stall after a retiring mispredict.
// Ports   : clock, reset (synchronous, active-high; forces every output to 0)
//           rc  - retire_ctrl_if.slave (head slots in, commit outputs out)
//           perf_retired/perf_mispred/perf_stall [31:0] - only with RETIRE_PERF_EN
// Config  : RETIRE_PERF_EN adds free-running retire, mispredict and stall counters.
// Params  : RECOVER_CYCLES - stall cycles after the mispredict cycle (1..15)
module retire_ctrl
    import retire_ctrl_pkg::*;
#(
    parameter int unsigned RECOVER_CYCLES = 2
) (
    input  logic          clock,
    input  logic          reset,
    retire_ctrl_if.slave  rc
`ifdef RETIRE_PERF_EN
    ,
    output logic [31:0]   perf_retired,
    output logic [31:0]   perf_mispred,
    output logic [31:0]   perf_stall
`endif
);

    retire_state_e        state_q, state_d;
    logic [3:0]           count_q, count_d;

    rob_head_entry_t [2:0] head;
    logic [2:0]           valid_v, complete_v, mispred_v, uncondbr_v, halt_v;
    logic [2:0]           ret, stop;
    logic [1:0]           cnt;
    logic                 enable;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            head[k].valid    = rc.head_valid[k];
            head[k].complete = rc.head_complete[k];
            head[k].arch_idx = rc.head_arch_idx[k];
            head[k].phys_tag = rc.head_phys_tag[k];
            head[k].old_tag  = rc.head_old_tag[k];
            head[k].mispred  = rc.head_mispred[k];
            head[k].uncondbr = rc.head_uncondbr[k];
            head[k].halt     = rc.head_halt[k];
            valid_v[k]       = head[k].valid;
            complete_v[k]    = head[k].complete;
            mispred_v[k]     = head[k].mispred;
            uncondbr_v[k]    = head[k].uncondbr;
            halt_v[k]        = head[k].halt;
        end
    end

    assign enable = (state_q == RUN) & ~reset;

    retire_ctrl_select u_select (
        .enable   (enable),
        .valid    (valid_v),
        .complete (complete_v),
        .mispred  (mispred_v),
        .halt     (halt_v),
        .ret      (ret),
        .stop     (stop),
        .cnt      (cnt)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= RUN;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_comb begin
        state_d           = state_q;
        count_d           = count_q;
        rc.retire_out     = '0;
        rc.mispredict_out = '0;
        rc.rob_retire_cnt = '0;
        rc.free_valid     = '0;
        rc.free_tag       = '0;
        rc.squash         = 1'b0;
        rc.restore_map    = 1'b0;
        rc.frontend_stall = 1'b0;
        rc.halted         = 1'b0;

        if (!reset) begin
            rc.retire_out.retire1     = ret[0];
            rc.retire_out.retire2     = ret[1];
            rc.retire_out.retire3     = ret[2];
            rc.retire_out.arch_index1 = head[0].arch_idx;
            rc.retire_out.arch_index2 = head[1].arch_idx;
            rc.retire_out.arch_index3 = head[2].arch_idx;
            rc.retire_out.arch_tag1   = head[0].phys_tag;
            rc.retire_out.arch_tag2   = head[1].phys_tag;
            rc.retire_out.arch_tag3   = head[2].phys_tag;
            rc.retire_out.uncondbr1   = head[0].uncondbr;
            rc.retire_out.uncondbr2   = head[1].uncondbr;
            rc.retire_out.uncondbr3   = head[2].uncondbr;

            rc.mispredict_out = ret & mispred_v;
            rc.rob_retire_cnt = cnt;
            for (int k = 0; k < 3; k++) begin
                // A mispredicted conditional branch has no live destination; a jump
                // still writes its link register, so its old mapping is released.
                rc.free_valid[k] = ret[k] & (head[k].arch_idx != ZERO_REG)
                                 & (~mispred_v[k] | uncondbr_v[k]);
                rc.free_tag[k]   = head[k].old_tag;
            end
            // The arch map snapshot is only coherent in the mispredict cycle itself.
            rc.squash      = |(ret & mispred_v);
            rc.restore_map = |(ret & mispred_v);

            unique case (state_q)
                RUN: begin
                    if (|(ret & stop)) begin
                        if (|(ret & halt_v)) begin
                            state_d = HALTED;
                        end else begin
                            state_d = RECOVER;
                            count_d = 4'(RECOVER_CYCLES);
                        end
                    end
                end
                RECOVER: begin
                    rc.frontend_stall = 1'b1;
                    count_d           = count_q - 4'd1;
                    if (count_q == 4'd1) state_d = RUN;
                end
                HALTED: begin
                    rc.frontend_stall = 1'b1;
                    rc.halted         = 1'b1;
                end
                default: state_d = RUN;
            endcase
        end
    end

`ifdef RETIRE_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_retired <= '0;
            perf_mispred <= '0;
            perf_stall   <= '0;
        end else begin
            perf_retired <= perf_retired + 32'(rc.rob_retire_cnt);
            perf_mispred <= perf_mispred + 32'(rc.squash);
            perf_stall   <= perf_stall + 32'(rc.frontend_stall);
        end
    end
`endif

endmodule

// File: tb/tb_retire_ctrl.sv
// tb/tb_retire_ctrl.sv - scoreboard bench for retire_ctrl with directed head vectors
module tb_retire_ctrl;
    import retire_ctrl_pkg::*;

    typedef struct packed {
        logic [1:0]  cnt;
        logic [2:0]  ret;
        logic [2:0]  ubr;
        logic [2:0]  misp;
        logic [2:0]  fv;
        logic [17:0] ft;
        logic        squash;
        logic        restore;
        logic        stall;
        logic        halted;
    } obs_t;

    logic clock = 1'b0;
    logic reset = 1'b1;

    retire_ctrl_if rc ();

`ifdef RETIRE_PERF_EN
    logic [31:0] perf_retired, perf_mispred, perf_stall;
`endif

    retire_ctrl #(.RECOVER_CYCLES(2)) dut (
        .clock (clock),
        .reset (reset),
        .rc    (rc)
`ifdef RETIRE_PERF_EN
        ,
        .perf_retired (perf_retired),
        .perf_mispred (perf_mispred),
        .perf_stall   (perf_stall)
`endif
    );

    always #5 clock = ~clock;

    obs_t  exp_q[$];
    string name_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    // Monitor: every cycle the DUT presents a fresh combinational output set.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            obs_t  e, a;
            string n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a.cnt     = rc.rob_retire_cnt;
            a.ret     = {rc.retire_out.retire3, rc.retire_out.retire2, rc.retire_out.retire1};
            a.ubr     = {rc.retire_out.uncondbr3, rc.retire_out.uncondbr2, rc.retire_out.uncondbr1};
            a.misp    = rc.mispredict_out;
            a.fv      = rc.free_valid;
            a.ft      = rc.free_tag;
            a.squash  = rc.squash;
            a.restore = rc.restore_map;
            a.stall   = rc.frontend_stall;
            a.halted  = rc.halted;
            n_cmp++;
            if (a !== e) begin
                n_bad++;
                $display("FAIL %s: got cnt=%0d ret=%b ubr=%b misp=%b fv=%b ft=%h sq=%b rm=%b st=%b h=%b ; want cnt=%0d ret=%b ubr=%b misp=%b fv=%b ft=%h sq=%b rm=%b st=%b h=%b",
                         n, a.cnt, a.ret, a.ubr, a.misp, a.fv, a.ft, a.squash, a.restore, a.stall, a.halted,
                         e.cnt, e.ret, e.ubr, e.misp, e.fv, e.ft, e.squash, e.restore, e.stall, e.halted);
            end
        end
    end

    // Drives one cycle of head state and queues the hand-computed response.
    task automatic step(input string nm, input logic rst,
                        input logic [2:0] v, input logic [2:0] c,
                        input logic [14:0] idx, input logic [17:0] old,
                        input logic [2:0] mp, input logic [2:0] ub, input logic [2:0] ht,
                        input logic [1:0] e_cnt, input logic [2:0] e_ret,
                        input logic [2:0] e_misp, input logic [2:0] e_fv,
                        input logic e_sq, input logic e_st, input logic e_h);
        obs_t e;
        @(posedge clock);
        #1;
        reset             = rst;
        rc.head_valid     = v;
        rc.head_complete  = c;
        rc.head_arch_idx  = idx;
        rc.head_phys_tag  = {6'd42, 6'd41, 6'd40};
        rc.head_old_tag   = old;
        rc.head_mispred   = mp;
        rc.head_uncondbr  = ub;
        rc.head_halt      = ht;
        e.cnt     = e_cnt;
        e.ret     = e_ret;
        e.ubr     = rst ? 3'b000 : ub;
        e.misp    = e_misp;
        e.fv      = e_fv;
        e.ft      = rst ? 18'd0 : old;
        e.squash  = e_sq;
        e.restore = e_sq;
        e.stall   = e_st;
        e.halted  = e_h;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    localparam logic [14:0] IDX1 = {5'd5, 5'd4, 5'd3};
    localparam logic [17:0] OLD1 = {6'd5, 6'd4, 6'd3};

    initial begin
        rc.head_valid    = '0;
        rc.head_complete = '0;
        rc.head_arch_idx = '0;
        rc.head_phys_tag = '0;
        rc.head_old_tag  = '0;
        rc.head_mispred  = '0;
        rc.head_uncondbr = '0;
        rc.head_halt     = '0;

        //       name            rst v      c      idx                    old                     mp     ub     ht    cnt  ret    misp   fv    sq st h
        step("reset_a",          1, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 0, 0);
        step("reset_b",          1, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 0, 0);
        step("all3_retire",      0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 3, 3'b111,3'b000,3'b111, 0, 0, 0);
        step("zero_reg_dest",    0, 3'b111, 3'b111, {5'd5,5'd0,5'd3},      {6'd5,6'd9,6'd3},       3'b000,3'b000,3'b000, 3, 3'b111,3'b000,3'b101, 0, 0, 0);
        step("slot0_incomplete", 0, 3'b111, 3'b110, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 0, 0);
        step("slot1_mispred",    0, 3'b111, 3'b111, {5'd6,5'd0,5'd7},      {6'd6,6'd9,6'd7},       3'b010,3'b000,3'b000, 2, 3'b011,3'b010,3'b001, 1, 0, 0);
        step("recover_1",        0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 1, 0);
        step("recover_2",        0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 1, 0);
        step("run_after_rec",    0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 3, 3'b111,3'b000,3'b111, 0, 0, 0);
        step("jal_mispred",      0, 3'b001, 3'b001, {5'd0,5'd0,5'd1},      {6'd0,6'd0,6'd1},       3'b001,3'b001,3'b000, 1, 3'b001,3'b001,3'b001, 1, 0, 0);
        step("jal_recover_1",    0, 3'b000, 3'b000, 15'd0,                 18'd0,                  3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 1, 0);
        step("jal_recover_2",    0, 3'b000, 3'b000, 15'd0,                 18'd0,                  3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 1, 0);
        step("idle_run",         0, 3'b000, 3'b000, 15'd0,                 18'd0,                  3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 0, 0);
        step("halt_then_misp",   0, 3'b011, 3'b011, {5'd0,5'd2,5'd1},      {6'd0,6'd2,6'd1},       3'b010,3'b000,3'b001, 1, 3'b001,3'b000,3'b001, 0, 0, 0);
        step("halted_1",         0, 3'b011, 3'b011, {5'd0,5'd2,5'd1},      {6'd0,6'd2,6'd1},       3'b010,3'b000,3'b001, 0, 3'b000,3'b000,3'b000, 0, 1, 1);
        step("halted_sticky",    0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 1, 1);
        step("reset_in_halt",    1, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 0, 0);
        step("run_after_halt",   0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 3, 3'b111,3'b000,3'b111, 0, 0, 0);
        step("mispred_again",    0, 3'b111, 3'b111, {5'd6,5'd0,5'd7},      {6'd6,6'd9,6'd7},       3'b010,3'b000,3'b000, 2, 3'b011,3'b010,3'b001, 1, 0, 0);
        step("recover_1b",       0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 1, 0);
        step("reset_in_recover", 1, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 0, 0);
        step("run_after_reset",  0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 3, 3'b111,3'b000,3'b111, 0, 0, 0);
        step("mispred_perf",     0, 3'b111, 3'b111, {5'd6,5'd0,5'd7},      {6'd6,6'd9,6'd7},       3'b010,3'b000,3'b000, 2, 3'b011,3'b010,3'b001, 1, 0, 0);
        step("recover_perf",     0, 3'b111, 3'b111, IDX1,                  OLD1,                   3'b000,3'b000,3'b000, 0, 3'b000,3'b000,3'b000, 0, 1, 0);

`ifdef RETIRE_PERF_EN
        // Since the last reset: 3 retired, then 2 with one mispredict.
        n_cmp++;
        if (perf_retired !== 32'd5) begin
            n_bad++;
            $display("FAIL perf_retired: got %0d want 5", perf_retired);
        end
        n_cmp++;
        if (perf_mispred !== 32'd1) begin
            n_bad++;
            $display("FAIL perf_mispred: got %0d want 1", perf_mispred);
        end
`endif

        repeat (3) @(posedge clock);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
